// File: rtl/mult_8x8_seq_sched.sv
// Sequential 8x8 multiplier scheduler. One external 4x4 multiplier is reused
// over up to four nibble steps; partial products are recombined either by
// exact addition or with the two middle terms OR-compressed.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and R is held stable for as long as out_valid stays high.
module mult_8x8_seq_sched #(
  parameter int SKIP_ZERO = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             mode,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      R,
  output logic [CNT_W-1:0] op_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_a;
  logic [7:0]         r_b;
  logic               r_mode;
  logic [7:0]         r_lo;
  logic [8:0]         r_mid;
  logic [7:0]         r_hi;
  logic [15:0]        r_r;
  logic [CNT_W-1:0]   r_cnt;

  logic [3:0]         w_in_mask;
  logic [3:0]         w_mask;
  logic [1:0]         w_idx;
  logic               w_step_act;
  logic [3:0]         w_mul_a;
  logic [3:0]         w_mul_b;
  logic [7:0]         w_lo_nxt;
  logic [8:0]         w_mid_nxt;
  logic [7:0]         w_hi_nxt;
  logic [15:0]        w_r_nxt;

  // Step k multiplies A nibble k[1] by B nibble k[0]; a step is active unless
  // zero-skipping is enabled and one of its nibbles is zero.
  function automatic logic [3:0] act_mask(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] m;
    logic [3:0] an;
    logic [3:0] bn;
    m = 4'd0;
    for (int k = 0; k < 4; k++) begin
      an   = (k >= 2) ? a[7:4] : a[3:0];
      bn   = (k % 2 == 1) ? b[7:4] : b[3:0];
      m[k] = (SKIP_ZERO == 0) || ((an != 4'd0) && (bn != 4'd0));
    end
    return m;
  endfunction

  // Lowest active step with index >= from, or DONE when none remain.
  function automatic state_t first_from(input logic [3:0] m, input logic [2:0] from);
    state_t s;
    s = DONE;
    for (int k = 3; k >= 0; k--) begin
      if ((k >= int'(from)) && m[k]) s = state_t'(3'(k + 1));
    end
    return s;
  endfunction

  // Next-state selection; with no active step the FSM still passes through S0
  // with the multiplier idle, so a result never appears on the accept edge.
  always_comb begin
    w_state_nxt = r_state;
    w_idx       = 2'd0;
    w_step_act  = 1'b0;
    w_in_mask   = act_mask(A, B);
    w_mask      = act_mask(r_a, r_b);
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = (w_in_mask == 4'd0) ? S0 : first_from(w_in_mask, 3'd0);
      end
      S0: begin
        w_idx       = 2'd0;
        w_step_act  = w_mask[0];
        w_state_nxt = first_from(w_mask, 3'd1);
      end
      S1: begin
        w_idx       = 2'd1;
        w_step_act  = w_mask[1];
        w_state_nxt = first_from(w_mask, 3'd2);
      end
      S2: begin
        w_idx       = 2'd2;
        w_step_act  = w_mask[2];
        w_state_nxt = first_from(w_mask, 3'd3);
      end
      S3: begin
        w_idx       = 2'd3;
        w_step_act  = w_mask[3];
        w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Multiplier operands and next partial values; mul_r is only consumed in an active step.
  always_comb begin
    w_mul_a   = 4'd0;
    w_mul_b   = 4'd0;
    w_lo_nxt  = r_lo;
    w_mid_nxt = r_mid;
    w_hi_nxt  = r_hi;
    if ((r_state == IDLE) && in_valid) begin
      w_lo_nxt  = 8'd0;
      w_mid_nxt = 9'd0;
      w_hi_nxt  = 8'd0;
    end
    if (w_step_act) begin
      w_mul_a = w_idx[1] ? r_a[7:4] : r_a[3:0];
      w_mul_b = w_idx[0] ? r_b[7:4] : r_b[3:0];
      case (w_idx)
        2'd0:    w_lo_nxt  = mul_r;
        2'd3:    w_hi_nxt  = mul_r;
        default: w_mid_nxt = r_mode ? (r_mid | {1'b0, mul_r}) : (r_mid + {1'b0, mul_r});
      endcase
    end
    w_r_nxt = {8'h00, w_lo_nxt} + {3'b000, w_mid_nxt, 4'h0} + {w_hi_nxt, 8'h00};
  end

  // State, operand, partial, result and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_mode  <= 1'b0;
      r_lo    <= 8'd0;
      r_mid   <= 9'd0;
      r_hi    <= 8'd0;
      r_r     <= 16'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lo    <= w_lo_nxt;
      r_mid   <= w_mid_nxt;
      r_hi    <= w_hi_nxt;
      if ((r_state == IDLE) && in_valid) begin
        r_a    <= A;
        r_b    <= B;
        r_mode <= mode;
      end
      if ((r_state != DONE) && (w_state_nxt == DONE)) r_r <= w_r_nxt;
      if ((r_state == DONE) && out_ready) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign mul_a     = w_mul_a;
  assign mul_b     = w_mul_b;
  assign R         = r_r;
  assign op_count  = r_cnt;
  assign dbg_state = r_state;

endmodule
